// File: rtl/alu_result_rx_pkg.sv
// Shared types and constants for the ALU result receiver slice (package alu_pkg).
package alu_pkg;

  localparam int unsigned ALU_VAL_W = 5;
  localparam int unsigned ALU_RES_W = 32;

  // One buffered result with the check outcomes recorded on acceptance.
  typedef struct packed {
    logic [ALU_VAL_W-1:0] value;
    logic                 err_par;
    logic                 err_ext;
  } alu_entry_t;

  // 1 when the value holds an even number of ones.
  function automatic logic even_ones(input logic [ALU_VAL_W-1:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/alu_result_rx_if.sv
// Producer-side and consumer-side handshakes of the ALU result receiver.
interface alu_result_rx_if;
  import alu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [ALU_RES_W-1:0] in_result;
  logic                 in_balance;
  logic                 out_valid;
  logic                 out_ready;
  logic [ALU_VAL_W-1:0] out_value;
  logic                 out_err_par;
  logic                 out_err_ext;

  // Receiver side.
  modport slave (
    input  in_valid, in_result, in_balance, out_ready,
    output in_ready, out_valid, out_value, out_err_par, out_err_ext
  );

  // Environment side: drives results in and drains the FIFO head.
  modport master (
    output in_valid, in_result, in_balance, out_ready,
    input  in_ready, out_valid, out_value, out_err_par, out_err_ext
  );
endinterface

// File: rtl/alu_result_rx_fifo.sv
// alu_rx_fifo: synchronous FIFO of DEPTH entries (power of two), registered head,
// no write-to-read bypass; occupancy counter separates full from empty.
module alu_rx_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = alu_pkg::alu_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/alu_result_rx.sv
// alu_result_rx: accepts sign-extended 5-bit ALU results, checks parity and
// sign extension, buffers value+flags, and counts transfers and errors.
// Optional macro ALU_RX_ERR_DROP_EN: erroneous results are counted but not enqueued.
module alu_result_rx
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_result_rx_if.slave       bus,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [15:0]          rx_count
);
  logic       full;
  logic       empty;
  logic       accept;
  logic       push;
  logic       pop;
  logic       err_par;
  logic       err_ext;
  logic       any_err;
  alu_entry_t wentry;
  alu_entry_t rentry;

  // Input checks on the offered result.
  always_comb begin
    err_par = (bus.in_balance != even_ones(bus.in_result[ALU_VAL_W-1:0]));
    err_ext = (bus.in_result[ALU_RES_W-1:ALU_VAL_W] !=
               {(ALU_RES_W-ALU_VAL_W){bus.in_result[ALU_VAL_W-1]}});
    any_err = err_par || err_ext;
    wentry.value   = bus.in_result[ALU_VAL_W-1:0];
    wentry.err_par = err_par;
    wentry.err_ext = err_ext;
  end

  assign bus.in_ready = !full && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
`ifdef ALU_RX_ERR_DROP_EN
  assign push = accept && !any_err;
`else
  assign push = accept;
`endif
  assign pop  = !empty && bus.out_ready;

  alu_rx_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (alu_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (rentry),
    .full  (full),
    .empty (empty)
  );

  // Head outputs forced to zero while nothing is buffered.
  always_comb begin
    bus.out_valid   = !empty;
    bus.out_value   = empty ? '0 : rentry.value;
    bus.out_err_par = empty ? 1'b0 : rentry.err_par;
    bus.out_err_ext = empty ? 1'b0 : rentry.err_ext;
  end

  // Transfer counter wraps; error counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count  <= '0;
      err_count <= '0;
    end else if (accept) begin
      rx_count <= rx_count + 16'd1;
      if (any_err && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end
endmodule
